ex_stage: RTL
=============

# ex_stage

Execute stage of the 5-stage MIPS pipeline, between decode and memory. It registers the decode bus and computes the ALU result, the data-SRAM request and the forwarding bus back to decode. It also owns the HI/LO registers, executes mult/multu/mfhi/mflo/mthi/mtlo, and runs an optional iterative divider that stalls the pipeline through `stallreq`.

## Interface
Parameters: none; widths come from the shared defines header (`ID_TO_EX_WD`=164, `EX_TO_MEM_WD`=81, `EX_TO_RF_WD`=38, `StallBus`=6).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  squash the stage register
- stall  in  `StallBus`  pipeline stall vector; bit 2 = EX, bit 3 = MEM
- id_to_ex_bus  in  164  fields, MSB→LSB: mem_op[5], pc[32], inst[32], alu_op[12], sel_alu_src1[3], sel_alu_src2[4], data_ram_en, data_ram_wen[4], rf_we, rf_waddr[5], sel_rf_res, rs_data[32], rt_data[32]
- ex_to_mem_bus  out  81  fields, MSB→LSB: mem_op[5], pc[32], data_ram_en, data_ram_wen[4], sel_rf_res, rf_we, rf_waddr[5], ex_result[32]
- ex_to_rf_bus  out  38  {rf_we, rf_waddr[5], ex_result[32]}, forwarded to decode
- data_sram_en  out  1  data-RAM access enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  ALU result
- data_sram_wdata  out  32  rt_data
- stallreq  out  1  hold pipeline while a divide is incomplete

## Operation
- Stage register, in priority order: rst→0; flush→0; stall[2]=Stop & stall[3]=NoStop→0 (bubble); stall[2]=NoStop→load id_to_ex_bus; otherwise hold.
- src1: rs_data / pc / zero-extended sa (inst[10:6]), per one-hot sel_alu_src1.
- src2: rt_data / sign-extended imm / 32'd8 / zero-extended imm, per sel_alu_src2.
- alu_op is one-hot {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}.
  - Shifts use src1[4:0] as the amount and src2 as the value.
  - lui = {src2[15:0],16'b0}.
  - add/sub wrap modulo 2^32; no overflow trap.
- Extra decode from `inst` (opcode 0, by func): mult 0x18, multu 0x19, div 0x1A, divu 0x1B, mfhi 0x10, mflo 0x12, mthi 0x11, mtlo 0x13.
- ex_result = HI for mfhi, LO for mflo, ALU result otherwise.
- mult/multu: single-cycle 64-bit product; {HI,LO} ← product.
- mthi/mtlo: HI or LO ← rs_data.
- div/divu: LO ← quotient, HI ← remainder.
  - Signed division truncates toward zero; remainder takes the dividend's sign.
  - Divide-by-zero: LO=0xFFFFFFFF (signed: -1 on dividend sign, i.e. 0x00000001 if dividend<0), HI=dividend.
  - 0x80000000 / -1: LO=0x80000000, HI=0.
- HI/LO write enable: instruction valid & stall[2]=NoStop & ~flush (for divide, additionally state DONE). HI/LO reset to 0.
- data_sram_en = data_ram_en; data_sram_wen = data_ram_wen & {4{data_ram_en}}.

Divider FSM (IDLE, BUSY, DONE):
- IDLE→BUSY when a div/divu sits in the stage register; latch operand magnitudes and signs; counter←0.
- BUSY: one restoring quotient bit per cycle; →DONE after 32 iterations.
- DONE→IDLE when stall[2]=NoStop (HI/LO written that edge); holds otherwise.
- flush or rst in any state →IDLE, no HI/LO write.
- stallreq = div_op & (state≠DONE).

## Timing
- ALU, SRAM request and forwarding bus are combinational from the stage register; one-cycle stage latency.
- All outputs are 0 after reset, including stallreq, rf_we and data_sram_en.
- Divide sequence, with cycle 0 = div in the register:
  - stallreq high in cycles 0–32.
  - DONE in cycle 33, stallreq low.
  - HI/LO updated at the end of cycle 33.
- An mfhi in the cycle after an advancing div/mult/mthi reads the new value.

## Configuration
- `EX_DIV_EN` defined: the divider FSM and the ex_div instance are built as above.
- `EX_DIV_EN` undefined:
  - div/divu complete in one cycle with HI=LO=0.
  - stallreq is tied 0.
  - No ex_div instance.

## Structure
- Shared defines header: bus widths, func codes for HI/LO ops, `Stop`/`NoStop`, divider state encodings.
- Sub-module `ex_div`: holds the FSM, counter and 64-bit remainder/quotient shift register. Inputs: start, signed, dividend, divisor, annul. Outputs: busy, done, quotient, remainder.

## Test plan
- addu, rs=5, rt=7, rf_waddr=3 → ex_to_rf_bus={1,3,12} in the same cycle.
- sw, base=0x100, imm=8, rt=0xDEADBEEF → en=1, wen=4'hF, addr=0x108, wdata=0xDEADBEEF.
- div −7 / 2 → stallreq high 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; a following mflo returns 0xFFFFFFFD.
- divu 10 / 0 → LO=0xFFFFFFFF, HI=10.
- flush asserted in cycle 10 of a div → FSM IDLE next cycle, stallreq 0, HI/LO unchanged.
- mult 0xFFFFFFFF × 2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands → HI=1, LO=0xFFFFFFFE.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared definitions for the MIPS execute stage.
//   - bus widths (ID_TO_EX_WD, EX_TO_MEM_WD, EX_TO_RF_WD, StallBus)
//   - Stop/NoStop stall encodings
//   - func codes of the HI/LO instructions (opcode 0)
//   - divider FSM state encoding
//   - packed layout of the decode-to-execute bus
//   - conditional two's-complement negate helper
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 164;
  localparam int EX_TO_MEM_WD = 81;
  localparam int EX_TO_RF_WD  = 38;
  localparam int StallBus     = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;
  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Field order matches the decode bus, MSB first.
  typedef struct packed {
    logic [4:0]  mem_op;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;        // {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}
    logic [2:0]  sel_alu_src1;  // {sa, pc, rs}
    logic [3:0]  sel_alu_src2;  // {zimm, 8, simm, rt}
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
  } id_ex_t;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] val);
    return neg ? (~val + 32'd1) : val;
  endfunction

endpackage

// File: rtl/ex_div.sv
// ex_div: iterative restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_start             a div/divu sits in the execute register
//   i_signed            1 = div, 0 = divu
//   i_dividend/divisor  operands (rs / rt)
//   i_annul             return to IDLE without result (flush or result consumed)
//   o_busy, o_done      FSM in BUSY / DONE
//   o_quotient          sign-corrected quotient (valid in DONE)
//   o_remainder         sign-corrected remainder (valid in DONE)
// Operand magnitudes are divided; signs are reapplied at the output, so the
// quotient truncates toward zero and the remainder follows the dividend.
// A zero divisor yields an all-ones magnitude quotient and the dividend as
// remainder without any special casing.
module ex_div
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  input  logic        i_annul,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  div_state_e  r_state;
  div_state_e  w_state_nxt;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;      // {partial remainder, dividend/quotient bits}
  logic [31:0] r_divisor;
  logic        r_neg_q;
  logic        r_neg_r;

  logic [32:0] w_top;
  logic        w_ge;
  logic [31:0] w_sub;

  // Shifted partial remainder can reach 33 bits before the trial subtract.
  assign w_top = r_acc[63:31];
  assign w_ge  = (w_top >= {1'b0, r_divisor});
  assign w_sub = w_top[31:0] - r_divisor;

  // Next-state logic of the divider FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE: begin
        if (i_annul)      w_state_nxt = DIV_IDLE;
        else if (i_start) w_state_nxt = DIV_BUSY;
        else              w_state_nxt = DIV_IDLE;
      end
      DIV_BUSY: begin
        if (i_annul)              w_state_nxt = DIV_IDLE;
        else if (r_cnt == 5'd31)  w_state_nxt = DIV_DONE;
        else                      w_state_nxt = DIV_BUSY;
      end
      DIV_DONE: begin
        if (i_annul) w_state_nxt = DIV_IDLE;
        else         w_state_nxt = DIV_DONE;
      end
      default: w_state_nxt = DIV_IDLE;
    endcase
  end

  // Divider FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DIV_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand latch and shift/subtract datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 5'd0;
      r_acc     <= 64'd0;
      r_divisor <= 32'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (i_start && !i_annul) begin
            r_cnt     <= 5'd0;
            r_acc     <= {32'd0, neg_if(i_signed & i_dividend[31], i_dividend)};
            r_divisor <= neg_if(i_signed & i_divisor[31], i_divisor);
            r_neg_q   <= i_signed & (i_dividend[31] ^ i_divisor[31]);
            r_neg_r   <= i_signed & i_dividend[31];
          end
        end
        DIV_BUSY: begin
          if (!i_annul) begin
            r_acc <= w_ge ? {w_sub, r_acc[30:0], 1'b1}
                          : {w_top[31:0], r_acc[30:0], 1'b0};
            r_cnt <= r_cnt + 5'd1;
          end
        end
        DIV_DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= 5'd0;
        end
      endcase
    end
  end

  assign o_busy      = (r_state == DIV_BUSY);
  assign o_done      = (r_state == DIV_DONE);
  assign o_quotient  = neg_if(r_neg_q, r_acc[31:0]);
  assign o_remainder = neg_if(r_neg_r, r_acc[63:32]);

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   flush            squash the stage register (and any divide in flight)
//   stall            stall vector; bit 2 = EX, bit 3 = MEM
//   id_to_ex_bus     decode bus (see ex_stage_pkg::id_ex_t)
//   ex_to_mem_bus    {mem_op, pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   ex_to_rf_bus     {rf_we, rf_waddr, ex_result} forwarded to decode
//   data_sram_*      data-RAM request, combinational from the stage register
//   stallreq         hold the pipeline while a divide is incomplete
// Build option: define EX_DIV_EN to build the iterative divider (ex_div).
// Without it div/divu complete in one cycle writing HI=LO=0, stallreq=0.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [StallBus-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq
);

  id_ex_t      r_bus;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // Stage register: reset/flush/bubble clear it, otherwise load or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          r_bus <= '0;
    else if (flush)                                   r_bus <= '0;
    else if (stall[2] == Stop && stall[3] == NoStop)  r_bus <= '0;
    else if (stall[2] == NoStop)                      r_bus <= id_ex_t'(id_to_ex_bus);
    else                                              r_bus <= r_bus;
  end

  // HI/LO instruction decode (opcode 0, by func).
  logic       w_rtype;
  logic [5:0] w_func;
  logic w_is_mult, w_is_multu, w_is_div, w_is_divu;
  logic w_is_mfhi, w_is_mflo, w_is_mthi, w_is_mtlo, w_div_op;

  assign w_rtype    = (r_bus.inst[31:26] == 6'd0);
  assign w_func     = r_bus.inst[5:0];
  assign w_is_mult  = w_rtype && (w_func == FUNC_MULT);
  assign w_is_multu = w_rtype && (w_func == FUNC_MULTU);
  assign w_is_div   = w_rtype && (w_func == FUNC_DIV);
  assign w_is_divu  = w_rtype && (w_func == FUNC_DIVU);
  assign w_is_mfhi  = w_rtype && (w_func == FUNC_MFHI);
  assign w_is_mflo  = w_rtype && (w_func == FUNC_MFLO);
  assign w_is_mthi  = w_rtype && (w_func == FUNC_MTHI);
  assign w_is_mtlo  = w_rtype && (w_func == FUNC_MTLO);
  assign w_div_op   = w_is_div | w_is_divu;

  // ALU operand selection (one-hot AND-OR muxes).
  logic [31:0] w_src1, w_src2;
  logic [31:0] w_simm, w_zimm, w_sa;

  assign w_simm = {{16{r_bus.inst[15]}}, r_bus.inst[15:0]};
  assign w_zimm = {16'd0, r_bus.inst[15:0]};
  assign w_sa   = {27'd0, r_bus.inst[10:6]};

  assign w_src1 = ({32{r_bus.sel_alu_src1[0]}} & r_bus.rs_data)
                | ({32{r_bus.sel_alu_src1[1]}} & r_bus.pc)
                | ({32{r_bus.sel_alu_src1[2]}} & w_sa);

  assign w_src2 = ({32{r_bus.sel_alu_src2[0]}} & r_bus.rt_data)
                | ({32{r_bus.sel_alu_src2[1]}} & w_simm)
                | ({32{r_bus.sel_alu_src2[2]}} & 32'd8)
                | ({32{r_bus.sel_alu_src2[3]}} & w_zimm);

  // ALU: shifts take the amount from src1 and the value from src2.
  logic [31:0] w_sra;
  logic        w_slt, w_sltu;
  logic [31:0] w_alu_res;
  logic [11:0] w_op;

  assign w_op   = r_bus.alu_op;
  assign w_sra  = $signed(w_src2) >>> w_src1[4:0];
  assign w_slt  = ($signed(w_src1) < $signed(w_src2));
  assign w_sltu = (w_src1 < w_src2);

  assign w_alu_res = ({32{w_op[11]}} & (w_src1 + w_src2))
                   | ({32{w_op[10]}} & (w_src1 - w_src2))
                   | ({32{w_op[9]}}  & {31'd0, w_slt})
                   | ({32{w_op[8]}}  & {31'd0, w_sltu})
                   | ({32{w_op[7]}}  & (w_src1 & w_src2))
                   | ({32{w_op[6]}}  & ~(w_src1 | w_src2))
                   | ({32{w_op[5]}}  & (w_src1 | w_src2))
                   | ({32{w_op[4]}}  & (w_src1 ^ w_src2))
                   | ({32{w_op[3]}}  & (w_src2 << w_src1[4:0]))
                   | ({32{w_op[2]}}  & (w_src2 >> w_src1[4:0]))
                   | ({32{w_op[1]}}  & w_sra)
                   | ({32{w_op[0]}}  & {w_src2[15:0], 16'd0});

  // Result select: HI/LO reads override the ALU.
  logic [31:0] w_ex_result;
  always_comb begin
    w_ex_result = w_alu_res;
    if (w_is_mfhi)      w_ex_result = r_hi;
    else if (w_is_mflo) w_ex_result = r_lo;
    else                w_ex_result = w_alu_res;
  end

  // 33x33 signed multiply covers both mult (sign-extend) and multu (zero-extend).
  logic        w_msign;
  logic [65:0] w_prod_full;
  assign w_msign     = w_is_mult;
  assign w_prod_full = $signed({w_msign & r_bus.rs_data[31], r_bus.rs_data})
                     * $signed({w_msign & r_bus.rt_data[31], r_bus.rt_data});

  logic w_adv;
  assign w_adv = (stall[2] == NoStop) && !flush;

  logic        w_div_done;
  logic [31:0] w_div_quo;
  logic [31:0] w_div_rem;

`ifdef EX_DIV_EN
  logic w_div_busy_unused;

  ex_div u_div (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_div_op),
    .i_signed    (w_is_div),
    .i_dividend  (r_bus.rs_data),
    .i_divisor   (r_bus.rt_data),
    .i_annul     (flush | (w_div_done & (stall[2] == NoStop))),
    .o_busy      (w_div_busy_unused),
    .o_done      (w_div_done),
    .o_quotient  (w_div_quo),
    .o_remainder (w_div_rem)
  );

  assign stallreq = w_div_op & ~w_div_done;
`else
  // Divider not built: div/divu complete at once with a zero result.
  assign w_div_done = 1'b1;
  assign w_div_quo  = 32'd0;
  assign w_div_rem  = 32'd0;
  assign stallreq   = 1'b0;
`endif

  // HI/LO registers, written only when the instruction leaves the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_adv) begin
      if (w_is_mult || w_is_multu) begin
        r_hi <= w_prod_full[63:32];
        r_lo <= w_prod_full[31:0];
      end else if (w_is_mthi) begin
        r_hi <= r_bus.rs_data;
      end else if (w_is_mtlo) begin
        r_lo <= r_bus.rs_data;
      end else if (w_div_op && w_div_done) begin
        r_hi <= w_div_rem;
        r_lo <= w_div_quo;
      end
    end
  end

  assign ex_to_mem_bus = {r_bus.mem_op, r_bus.pc, r_bus.data_ram_en, r_bus.data_ram_wen,
                          r_bus.sel_rf_res, r_bus.rf_we, r_bus.rf_waddr, w_ex_result};
  assign ex_to_rf_bus  = {r_bus.rf_we, r_bus.rf_waddr, w_ex_result};

  assign data_sram_en    = r_bus.data_ram_en;
  assign data_sram_wen   = r_bus.data_ram_wen & {4{r_bus.data_ram_en}};
  assign data_sram_addr  = w_alu_res;
  assign data_sram_wdata = r_bus.rt_data;

  logic w_unused;
  assign w_unused = ^{r_bus.inst[25:16], w_prod_full[65:64], stall[5:4], stall[1:0]};

endmodule
